// File: rtl/fifo_pkg.sv
// Shared types and constants for the dual-clock FIFO and its read-side adapter.
// Data width is common to the FIFO core and every consumer.
package fifo_pkg;

    localparam int W_DATA       = 32;
    localparam int OQ_DEPTH_DEF = 2;
    localparam int CNT_W_DEF    = 16;

    typedef logic [W_DATA-1:0]    data_t;
    typedef logic [CNT_W_DEF-1:0] xfer_cnt_t;

endpackage

// File: rtl/fifo_oq_regfile.sv
// Output queue storage for the read stream adapter.
// One write port, asynchronous read; contents are intentionally not reset.
module fifo_oq_regfile
    import fifo_pkg::*;
#(
    parameter int DW    = W_DATA,
    parameter int DEPTH = OQ_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-domain adapter: FIFO pop/empty with 1-cycle read latency to a
// first-word-fall-through valid/ready stream with flush and transfer count.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int DW       = W_DATA,
    parameter int OQ_DEPTH = OQ_DEPTH_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    input  logic [DW-1:0]    fifo_rd_data,
    input  logic             flush,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] xfer_count,
    output logic             busy
);

    localparam int PW = $clog2(OQ_DEPTH);
    localparam int CW = $clog2(OQ_DEPTH) + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(OQ_DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(OQ_DEPTH - 1);

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;

    logic             accept;
    logic             capture;
    logic [CW-1:0]    credit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    // Credit counts words already queued plus the one on the RAM read port,
    // so a pop is only issued when a slot is guaranteed at capture time.
    always_comb begin
        m_valid    = (count_q != '0) & ~flush & ~rd_rst;
        accept     = m_valid & m_ready;
        capture    = inflight_q & ~flush;
        credit     = count_q + CW'(inflight_q) - CW'(accept);
        fifo_pop   = ~rd_rst & ~flush & ~fifo_empty & (credit < DEPTH_C);
        busy       = ~rd_rst & ((count_q != '0) | inflight_q);

        count_d    = count_q + CW'(capture) - CW'(accept);
        wr_ptr_d   = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = accept ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        inflight_d = fifo_pop;
        xfer_d     = xfer_q + CNT_W'(accept);

        if (flush) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            xfer_q     <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            xfer_q     <= xfer_d;
        end
    end

    assign xfer_count = xfer_q;

    fifo_oq_regfile #(
        .DW    (DW),
        .DEPTH (OQ_DEPTH),
        .AW    (PW)
    ) u_oq (
        .clk   (rd_clk),
        .we    (capture),
        .waddr (wr_ptr_q),
        .wdata (fifo_rd_data),
        .raddr (rd_ptr_q),
        .rdata (m_data)
    );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: instance A (depth 2, 16-bit
// count) and instance B (depth 3, 4-bit count), each fed by a FIFO model.
module tb_fifo_rd_stream_adapter;
    import fifo_pkg::*;

    localparam int DW = W_DATA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rd_rst_a = 1'b1, flush_a = 1'b0, m_ready_a = 1'b0;
    logic          fifo_empty_a = 1'b1, fifo_pop_a, m_valid_a, busy_a;
    logic [DW-1:0] fifo_rd_data_a = '0, m_data_a;
    logic [15:0]   xfer_count_a;

    logic          rst_b = 1'b1, flush_b = 1'b0, m_ready_b = 1'b0;
    logic          fifo_empty_b = 1'b1, fifo_pop_b, m_valid_b, busy_b;
    logic [DW-1:0] fifo_rd_data_b = '0, m_data_b;
    logic [3:0]    xfer_count_b;

    fifo_rd_stream_adapter #(.DW(DW), .OQ_DEPTH(2), .CNT_W(16)) dut_a (
        .rd_clk(clk), .rd_rst(rd_rst_a), .fifo_empty(fifo_empty_a),
        .fifo_pop(fifo_pop_a), .fifo_rd_data(fifo_rd_data_a),
        .flush(flush_a), .m_valid(m_valid_a), .m_data(m_data_a),
        .m_ready(m_ready_a), .xfer_count(xfer_count_a), .busy(busy_a)
    );

    fifo_rd_stream_adapter #(.DW(DW), .OQ_DEPTH(3), .CNT_W(4)) dut_b (
        .rd_clk(clk), .rd_rst(rst_b), .fifo_empty(fifo_empty_b),
        .fifo_pop(fifo_pop_b), .fifo_rd_data(fifo_rd_data_b),
        .flush(flush_b), .m_valid(m_valid_b), .m_data(m_data_b),
        .m_ready(m_ready_b), .xfer_count(xfer_count_b), .busy(busy_b)
    );

    logic [DW-1:0] fq_a[$], fq_b[$], got_a[$], got_b[$];
    int n_cmp = 0, n_bad = 0;
    int npop_a = 0, occ_viol = 0, pe_viol = 0;
    int tb_cnt = 0, tb_inf = 0;

    // FIFO models: registered read data, empty flag updated at the edge
    always @(posedge clk) begin
        if (fifo_pop_a && fq_a.size() > 0) fifo_rd_data_a <= fq_a.pop_front();
        fifo_empty_a <= (fq_a.size() == 0);
        if (fifo_pop_a) npop_a++;
        if (fifo_pop_b && fq_b.size() > 0) fifo_rd_data_b <= fq_b.pop_front();
        fifo_empty_b <= (fq_b.size() == 0);
        // occupancy of A: queued words plus word on the read port
        if (rd_rst_a || flush_a) begin
            tb_cnt = 0;
            tb_inf = 0;
        end else begin
            tb_cnt = tb_cnt + tb_inf - int'(m_valid_a & m_ready_a);
            tb_inf = int'(fifo_pop_a);
            if (tb_cnt + tb_inf > 2) occ_viol++;
        end
    end

    always @(negedge clk) begin
        if (m_valid_a && m_ready_a) got_a.push_back(m_data_a);
        if (m_valid_b && m_ready_b) got_b.push_back(m_data_b);
        if ((fifo_pop_a && fifo_empty_a) || (fifo_pop_b && fifo_empty_b)) pe_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic rst_all();
        rd_rst_a  = 1'b1;
        rst_b     = 1'b1;
        flush_a   = 1'b0;
        flush_b   = 1'b0;
        m_ready_a = 1'b0;
        m_ready_b = 1'b0;
        fq_a.delete();
        fq_b.delete();
        step();
        step();
        got_a.delete();
        got_b.delete();
    endtask

    task automatic wait_a(input string tag, input int n, input int budget);
        int k = 0;
        while (got_a.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, got_a.size(), n);
    endtask

    task automatic wait_b(input string tag, input int n, input int budget);
        int k = 0;
        while (got_b.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, got_b.size(), n);
    endtask

    initial begin
        // basic streaming, first-word latency
        rst_all();
        fq_a.push_back('h11);
        fq_a.push_back('h22);
        fq_a.push_back('h33);
        m_ready_a = 1'b1;
        step();
        smp();
        chk("rst_pop", fifo_pop_a, 0);
        chk("rst_valid", m_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_xfer", xfer_count_a, 0);
        step();
        rd_rst_a = 1'b0;
        smp();
        chk("c0_pop", fifo_pop_a, 1);
        chk("c0_valid", m_valid_a, 0);
        step();
        smp();
        chk("c1_pop", fifo_pop_a, 1);
        chk("c1_valid", m_valid_a, 0);
        step();
        smp();
        chk("c2_valid", m_valid_a, 1);
        chk("c2_data", m_data_a, 'h11);
        step();
        smp();
        chk("c3_data", m_data_a, 'h22);
        step();
        smp();
        chk("c4_data", m_data_a, 'h33);
        step();
        smp();
        chk("c5_valid", m_valid_a, 0);
        chk("c5_busy", busy_a, 0);
        chk("c5_xfer", xfer_count_a, 3);

        // back-pressure
        rst_all();
        for (int i = 0; i < 8; i++) fq_a.push_back(32'h80 + 32'(i));
        step();
        rd_rst_a = 1'b0;
        npop_a   = 0;
        for (int i = 0; i < 10; i++) begin
            smp();
            if (i == 3 || i == 9) begin
                chk("bp_pops", npop_a, 2);
                chk("bp_valid", m_valid_a, 1);
                chk("bp_hold", m_data_a, 'h80);
            end
            step();
        end
        m_ready_a = 1'b1;
        wait_a("bp_cnt", 8, 40);
        for (int i = 0; i < 8; i++) chk("bp_order", got_a[i], 32'h80 + 32'(i));
        step();
        smp();
        chk("bp_xfer", xfer_count_a, 8);
        chk("bp_occ", occ_viol, 0);

        // alternating ready
        rst_all();
        for (int i = 0; i < 16; i++) fq_a.push_back(32'h100 + 32'(i));
        step();
        rd_rst_a  = 1'b0;
        m_ready_a = 1'b1;
        for (int k = 0; k < 100 && got_a.size() < 16; k++) begin
            step();
            m_ready_a = ~m_ready_a;
        end
        chk("alt_cnt", got_a.size(), 16);
        for (int i = 0; i < 16; i++) chk("alt_order", got_a[i], 32'h100 + 32'(i));
        chk("alt_pop_empty", pe_viol, 0);
        chk("alt_occ", occ_viol, 0);

        // flush on B with two queued, one in flight (0xAA)
        rst_all();
        fq_b.push_back('h51);
        fq_b.push_back('h52);
        fq_b.push_back('hAA);
        fq_b.push_back('h53);
        step();
        rst_b = 1'b0;
        step();
        step();
        smp();
        chk("fl_pre_valid", m_valid_b, 1);
        chk("fl_pre_data", m_data_b, 'h51);
        chk("fl_pre_pop", fifo_pop_b, 1);
        step();
        flush_b   = 1'b1;
        m_ready_b = 1'b1;
        smp();
        chk("fl_valid", m_valid_b, 0);
        chk("fl_pop", fifo_pop_b, 0);
        step();
        flush_b = 1'b0;
        smp();
        chk("fl_busy", busy_b, 0);
        chk("fl_valid_nx", m_valid_b, 0);
        chk("fl_xfer", xfer_count_b, 0);
        chk("fl_pop_nx", fifo_pop_b, 1);
        wait_b("fl_cnt", 1, 20);
        chk("fl_word", got_b[0], 'h53);
        step();
        step();
        smp();
        chk("fl_no_aa", got_b.size(), 1);
        chk("fl_xfer_end", xfer_count_b, 1);

        // 4-bit counter wrap on B
        rst_all();
        for (int i = 0; i < 17; i++) fq_b.push_back(32'h200 + 32'(i));
        step();
        rst_b     = 1'b0;
        m_ready_b = 1'b1;
        wait_b("wr_cnt", 17, 60);
        step();
        smp();
        chk("wr_xfer", xfer_count_b, 1);
        chk("wr_last", got_b[16], 'h210);

        // reset mid-stream on A
        rst_all();
        for (int i = 0; i < 6; i++) fq_a.push_back(32'h61 + 32'(i));
        step();
        rd_rst_a  = 1'b0;
        m_ready_a = 1'b1;
        step();
        step();
        smp();
        chk("mr_first", m_data_a, 'h61);
        step();
        rd_rst_a = 1'b1;
        smp();
        chk("mr_pop", fifo_pop_a, 0);
        chk("mr_valid", m_valid_a, 0);
        chk("mr_busy", busy_a, 0);
        step();
        rd_rst_a = 1'b0;
        got_a.delete();
        smp();
        chk("mr_xfer", xfer_count_a, 0);
        chk("mr_busy_nx", busy_a, 0);
        chk("mr_valid_nx", m_valid_a, 0);
        chk("mr_pop_nx", fifo_pop_a, 1);
        wait_a("mr_cnt", 3, 20);
        for (int i = 0; i < 3; i++) chk("mr_order", got_a[i], 32'h64 + 32'(i));
        step();
        smp();
        chk("mr_xfer_end", xfer_count_a, 3);
        chk("end_pop_empty", pe_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
